// File: rtl/adpll_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adpll_pkg
// Purpose : Shared ADPLL types: phase detector FSM encoding, error width.
// Revision: 1.0 - initial release
// ============================================================================
package adpll_pkg;

  // Shared with the loop filter error input
  localparam int ADPLL_ERROR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REF_LEAD = 2'd1,
    FB_LEAD  = 2'd2
  } ped_state_e;

endpackage : adpll_pkg
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// ============================================================================
// Module  : edge_sync
// Purpose : Multi-flop synchronizer followed by a registered rising-edge pulse.
// Revision: 1.0 - initial release
// ============================================================================
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic gen_clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_last;
  logic                   r_rise;

  always_ff @(posedge gen_clk_i) begin
    if (reset_i) begin
      r_sync <= '0;
      r_last <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_i};
      r_last <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_last;
    end
  end

  assign rise_o = r_rise;

endmodule : edge_sync
`default_nettype wire

// File: rtl/phase_error_detector.sv
`default_nettype none
// ============================================================================
// Module  : phase_error_detector
// Purpose : Signed ref/feedback phase error in gen_clk cycles, plus lock flag.
// Revision: 1.0 - initial release
// ============================================================================
module phase_error_detector
  import adpll_pkg::*;
#(
  parameter int ERROR_WIDTH = ADPLL_ERROR_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_COUNT  = 16
) (
  input  logic                          gen_clk_i,
  input  logic                          reset_i,
  input  logic                          enable_i,
  input  logic                          ref_clk_i,
  input  logic                          fb_clk_i,
  output logic signed [ERROR_WIDTH-1:0] error_o,
  output logic                          error_valid_o,
  output logic                          lock_o
);

  localparam int LCW = $clog2(LOCK_COUNT + 1);

  localparam logic [ERROR_WIDTH-2:0]        c_cnt_max  = '1;
  localparam logic [ERROR_WIDTH-2:0]        c_cnt_one  = {{(ERROR_WIDTH-2){1'b0}}, 1'b1};
  localparam logic signed [ERROR_WIDTH-1:0] c_sat_pos  = {1'b0, {(ERROR_WIDTH-1){1'b1}}};
  localparam logic signed [ERROR_WIDTH-1:0] c_sat_neg  = -c_sat_pos;
  localparam logic [ERROR_WIDTH-1:0]        c_tol      = ERROR_WIDTH'(LOCK_TOL);
  localparam logic [LCW-1:0]                c_lock_max = LCW'(LOCK_COUNT);
  localparam logic [LCW-1:0]                c_lock_one = LCW'(1);

  logic w_ref_rise;
  logic w_fb_rise;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .gen_clk_i (gen_clk_i),
    .reset_i   (reset_i),
    .async_i   (ref_clk_i),
    .rise_o    (w_ref_rise)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .gen_clk_i (gen_clk_i),
    .reset_i   (reset_i),
    .async_i   (fb_clk_i),
    .rise_o    (w_fb_rise)
  );

  ped_state_e                   r_state, w_state_next;
  logic [ERROR_WIDTH-2:0]       r_cnt, w_cnt_next;
  logic signed [ERROR_WIDTH-1:0] r_error, w_error_next;
  logic                         r_valid, w_emit;
  logic signed [ERROR_WIDTH-1:0] w_cnt_pos;
  logic signed [ERROR_WIDTH-1:0] w_cnt_neg;

  assign w_cnt_pos = $signed({1'b0, r_cnt});
  assign w_cnt_neg = -w_cnt_pos;

  always_ff @(posedge gen_clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_error <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_error <= w_error_next;
      r_valid <= w_emit;
    end
  end

  // Matching edge wins over a slip; a slip wins over counter saturation.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_error_next = r_error;
    w_emit       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ref_rise && w_fb_rise) begin
          w_emit       = 1'b1;
          w_error_next = '0;
        end else if (w_ref_rise) begin
          w_state_next = REF_LEAD;
          w_cnt_next   = c_cnt_one;
        end else if (w_fb_rise) begin
          w_state_next = FB_LEAD;
          w_cnt_next   = c_cnt_one;
        end
      end
      REF_LEAD: begin
        if (w_fb_rise) begin
          w_emit       = 1'b1;
          w_error_next = w_cnt_pos;
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (w_ref_rise) begin
          w_emit       = 1'b1;
          w_error_next = c_sat_pos;
          w_cnt_next   = c_cnt_one;
        end else if (r_cnt == c_cnt_max) begin
          w_emit       = 1'b1;
          w_error_next = c_sat_pos;
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + c_cnt_one;
        end
      end
      FB_LEAD: begin
        if (w_ref_rise) begin
          w_emit       = 1'b1;
          w_error_next = w_cnt_neg;
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (w_fb_rise) begin
          w_emit       = 1'b1;
          w_error_next = c_sat_neg;
          w_cnt_next   = c_cnt_one;
        end else if (r_cnt == c_cnt_max) begin
          w_emit       = 1'b1;
          w_error_next = c_sat_neg;
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + c_cnt_one;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
    if (!enable_i) begin
      w_state_next = IDLE;
      w_cnt_next   = '0;
      w_error_next = '0;
      w_emit       = 1'b0;
    end
  end

  logic [LCW-1:0]         r_lock_cnt, w_lock_cnt_next;
  logic                   r_lock;
  logic [ERROR_WIDTH-1:0] w_abs;
  logic                   w_in_tol;

  // The most negative code is never produced, so negation cannot overflow.
  assign w_abs    = r_error[ERROR_WIDTH-1] ? $unsigned(-r_error) : $unsigned(r_error);
  assign w_in_tol = (w_abs <= c_tol);

  always_comb begin
    w_lock_cnt_next = '0;
    if (w_in_tol) begin
      w_lock_cnt_next = (r_lock_cnt == c_lock_max) ? c_lock_max : r_lock_cnt + c_lock_one;
    end
  end

  always_ff @(posedge gen_clk_i) begin
    if (reset_i || !enable_i) begin
      r_lock_cnt <= '0;
      r_lock     <= 1'b0;
    end else if (r_valid) begin
      r_lock_cnt <= w_lock_cnt_next;
      r_lock     <= (w_lock_cnt_next == c_lock_max);
    end
  end

  assign error_o       = r_error;
  assign error_valid_o = r_valid;
  assign lock_o        = r_lock;

endmodule : phase_error_detector
`default_nettype wire

// File: tb/tb_phase_error_detector.sv
`default_nettype none
// ============================================================================
// Module  : tb_phase_error_detector
// Purpose : Randomized self-checking bench for phase_error_detector.
// Revision: 1.0 - initial release
// ============================================================================
module tb_phase_error_detector;

  logic              gen_clk = 1'b0;
  logic              reset   = 1'b1;
  logic              enable  = 1'b1;
  logic              ref_clk = 1'b0;
  logic              fb_clk  = 1'b0;
  logic signed [7:0] error_o;
  logic              error_valid_o;
  logic              lock_o;

  int total = 0;
  int bad   = 0;

  logic signed [7:0] q_err[$];
  logic              q_lock_pre[$];
  logic              q_lock_post[$];
  logic              lock_pending = 1'b0;

  phase_error_detector #(
    .ERROR_WIDTH (8),
    .SYNC_STAGES (2),
    .LOCK_TOL    (2),
    .LOCK_COUNT  (16)
  ) dut (
    .gen_clk_i     (gen_clk),
    .reset_i       (reset),
    .enable_i      (enable),
    .ref_clk_i     (ref_clk),
    .fb_clk_i      (fb_clk),
    .error_o       (error_o),
    .error_valid_o (error_valid_o),
    .lock_o        (lock_o)
  );

  always #5 gen_clk = ~gen_clk;

  // Record each measurement and the lock flag on the valid cycle and the one after.
  always @(negedge gen_clk) begin
    if (lock_pending) begin
      q_lock_post.push_back(lock_o);
      lock_pending = 1'b0;
    end
    if (error_valid_o) begin
      q_err.push_back(error_o);
      q_lock_pre.push_back(lock_o);
      lock_pending = 1'b1;
    end
  end

  task automatic tick();
    @(posedge gen_clk);
    #1;
  endtask

  task automatic clear_q();
    q_err.delete();
    q_lock_pre.delete();
    q_lock_post.delete();
  endtask

  // Edge start times in gen_clk cycles; -1 means no edge. Each pulse is 2 cycles high.
  task automatic drive_pattern(input int r0, input int r1, input int f0, input int f1, input int len);
    for (int c = 0; c < len; c++) begin
      ref_clk = (r0 >= 0 && c >= r0 && c < r0 + 2) || (r1 >= 0 && c >= r1 && c < r1 + 2);
      fb_clk  = (f0 >= 0 && c >= f0 && c < f0 + 2) || (f1 >= 0 && c >= f1 && c < f1 + 2);
      tick();
    end
    ref_clk = 1'b0;
    fb_clk  = 1'b0;
    repeat (8) tick();
  endtask

  // d > 0: feedback lags the reference by d cycles
  task automatic run_pair(input int d);
    int mag;
    mag = (d < 0) ? -d : d;
    if (d >= 0) drive_pattern(0, -1, d, -1, mag + 3);
    else        drive_pattern(mag, -1, 0, -1, mag + 3);
  endtask

  function automatic int model_err(input int d);
    if (d > 127)  return 127;
    if (d < -127) return -127;
    return d;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total++; if (error_o !== 8'sd0) begin bad++; $display("FAIL reset_error got=%0d want=0", error_o); end
    total++; if (error_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", error_valid_o); end
    total++; if (lock_o !== 1'b0) begin bad++; $display("FAIL reset_lock got=%b want=0", lock_o); end
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    int pats[3] = '{5, -3, 0};
    logic signed [7:0] exp;
    foreach (pats[i]) begin
      clear_q();
      run_pair(pats[i]);
      exp = 8'(model_err(pats[i]));
      total++;
      if (q_err.size() != 1) begin
        bad++; $display("FAIL basic_count d=%0d got=%0d want=1", pats[i], q_err.size());
      end else if (q_err[0] !== exp) begin
        bad++; $display("FAIL basic_value d=%0d got=%0d want=%0d", pats[i], q_err[0], exp);
      end
      repeat (5) tick();
      total++;
      if (error_o !== exp) begin bad++; $display("FAIL basic_hold d=%0d got=%0d want=%0d", pats[i], error_o, exp); end
    end
  endtask

  task automatic test_saturation();
    int pats[2] = '{126, 127};
    foreach (pats[i]) begin
      clear_q();
      run_pair(pats[i]);
      total++;
      if (q_err.size() != 1 || q_err[0] !== 8'(model_err(pats[i]))) begin
        bad++; $display("FAIL sat_edge d=%0d got_n=%0d want=%0d", pats[i], q_err.size(), model_err(pats[i]));
      end
    end
    clear_q();
    drive_pattern(0, -1, -1, -1, 200);
    total++;
    if (q_err.size() != 1 || q_err[0] !== 8'sd127) begin
      bad++; $display("FAIL sat_ref_alone got_n=%0d want one +127", q_err.size());
    end
    clear_q();
    drive_pattern(-1, -1, 0, -1, 200);
    total++;
    if (q_err.size() != 1 || q_err[0] !== -8'sd127) begin
      bad++; $display("FAIL sat_fb_alone got_n=%0d want one -127", q_err.size());
    end
    clear_q();
    run_pair(4);
    total++;
    if (q_err.size() != 1 || q_err[0] !== 8'sd4) begin
      bad++; $display("FAIL sat_recover got_n=%0d want one +4", q_err.size());
    end
  endtask

  task automatic test_slip();
    clear_q();
    drive_pattern(0, 30, 37, -1, 40);
    total++;
    if (q_err.size() != 2 || q_err[0] !== 8'sd127 || q_err[1] !== 8'sd7) begin
      bad++; $display("FAIL slip_ref got_n=%0d want +127 then +7", q_err.size());
    end
    clear_q();
    drive_pattern(20, -1, 0, 12, 24);
    total++;
    if (q_err.size() != 2 || q_err[0] !== -8'sd127 || q_err[1] !== -8'sd8) begin
      bad++; $display("FAIL slip_fb got_n=%0d want -127 then -8", q_err.size());
    end
  endtask

  task automatic test_random();
    int d;
    for (int i = 0; i < 20; i++) begin
      d = int'($urandom_range(200, 0)) - 100;
      clear_q();
      run_pair(d);
      total++;
      if (q_err.size() != 1) begin
        bad++; $display("FAIL rand_count d=%0d got=%0d want=1", d, q_err.size());
      end else if (q_err[0] !== 8'(model_err(d))) begin
        bad++; $display("FAIL rand_value d=%0d got=%0d want=%0d", d, q_err[0], model_err(d));
      end
    end
  endtask

  task automatic test_lock();
    int  d, consec, mag;
    logic exp_lock, prev_lock;
    enable = 1'b0;
    repeat (2) tick();
    enable = 1'b1;
    tick();
    consec   = 0;
    exp_lock = 1'b0;
    for (int i = 0; i < 18; i++) begin
      d = (i == 17) ? 4 : int'($urandom_range(4, 0)) - 2;
      clear_q();
      run_pair(d);
      mag       = (d < 0) ? -d : d;
      prev_lock = exp_lock;
      consec    = (mag <= 2) ? ((consec < 16) ? consec + 1 : 16) : 0;
      exp_lock  = (consec >= 16);
      total++;
      if (q_err.size() != 1 || q_lock_pre.size() != 1 || q_lock_post.size() != 1) begin
        bad++; $display("FAIL lock_count i=%0d got=%0d want=1", i, q_err.size());
      end else if (q_err[0] !== 8'(d) || q_lock_pre[0] !== prev_lock || q_lock_post[0] !== exp_lock) begin
        bad++; $display("FAIL lock_seq i=%0d err=%0d/%0d pre=%b/%b post=%b/%b", i,
                        q_err[0], d, q_lock_pre[0], prev_lock, q_lock_post[0], exp_lock);
      end
    end
  endtask

  task automatic test_enable();
    for (int i = 0; i < 16; i++) run_pair((i == 15) ? 2 : int'($urandom_range(3, 0)) - 1);
    total++; if (lock_o !== 1'b1) begin bad++; $display("FAIL en_locked got=%b want=1", lock_o); end
    enable = 1'b0;
    repeat (2) tick();
    total++; if (lock_o !== 1'b0) begin bad++; $display("FAIL en_lock_clr got=%b want=0", lock_o); end
    total++; if (error_o !== 8'sd0) begin bad++; $display("FAIL en_err_zero got=%0d want=0", error_o); end
    clear_q();
    run_pair(10);
    run_pair(-3);
    total++;
    if (q_err.size() != 0 || error_o !== 8'sd0) begin
      bad++; $display("FAIL en_suppress got_n=%0d err=%0d want 0 pulses err 0", q_err.size(), error_o);
    end
    enable = 1'b1;
    tick();
    clear_q();
    run_pair(6);
    total++;
    if (q_err.size() != 1 || q_err[0] !== 8'sd6) begin
      bad++; $display("FAIL en_resume got_n=%0d want one +6", q_err.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    for (int c = 0; c < 13; c++) begin
      ref_clk = (c < 2);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (error_o !== 8'sd0 || error_valid_o !== 1'b0 || lock_o !== 1'b0) begin
      bad++; $display("FAIL rstmid_out err=%0d valid=%b lock=%b want 0/0/0", error_o, error_valid_o, lock_o);
    end
    repeat (150) tick();
    total++;
    if (q_err.size() != 0 || error_o !== 8'sd0) begin
      bad++; $display("FAIL rstmid_nopulse got_n=%0d err=%0d want 0 pulses", q_err.size(), error_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_slip();
    test_random();
    test_lock();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_phase_error_detector
`default_nettype wire

// File: doc/phase_error_detector.md
PHASE_ERROR_DETECTOR -- requirements
Module: phase_error_detector

Interface
REQ-001 SHALL have parameter ERROR_WIDTH, default 8, giving the width of the signed error output.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops per asynchronous input (minimum 2).
REQ-003 SHALL have parameter LOCK_TOL, default 2, giving the maximum |error| counted as in-lock.
REQ-004 SHALL have parameter LOCK_COUNT, default 16, giving the number of consecutive in-lock measurements needed to assert lock.
REQ-005 gen_clk_i  input  1  sampling clock; one clock, all logic on its rising edge.
REQ-006 reset_i  input  1  reset; synchronous, active-high.
REQ-007 enable_i  input  1  detector enable; low forces idle.
REQ-008 ref_clk_i  input  1  reference clock, asynchronous to gen_clk_i.
REQ-009 fb_clk_i  input  1  divided DCO feedback clock, asynchronous to gen_clk_i.
REQ-010 error_o  output  ERROR_WIDTH signed  phase error in gen_clk_i cycles; feeds the loop filter error input.
REQ-011 error_valid_o  output  1  one-cycle pulse marking a new error_o value.
REQ-012 lock_o  output  1  loop-locked indication.

Function
REQ-013 Each of ref_clk_i and fb_clk_i SHALL pass through SYNC_STAGES flops followed by a registered rising-edge detector, producing ref_rise and fb_rise.
REQ-014 FSM states SHALL be IDLE, REF_LEAD and FB_LEAD, with a magnitude counter cnt of ERROR_WIDTH-1 bits.
REQ-015 IDLE: ref_rise and fb_rise together -> error 0, stay IDLE; ref_rise alone -> REF_LEAD with cnt=1; fb_rise alone -> FB_LEAD with cnt=1.
REQ-016 REF_LEAD: fb_rise -> error=+cnt, go to IDLE; otherwise cnt increments by 1 per cycle.
REQ-017 FB_LEAD: ref_rise -> error=-cnt, go to IDLE; otherwise cnt increments by 1 per cycle.
REQ-018 Sign convention: positive error means feedback lags the reference, so the DCO must speed up.
REQ-019 Saturation: a cnt value of 2^(ERROR_WIDTH-1)-1 in REF_LEAD or FB_LEAD, with no matching edge, SHALL emit error +/-(2^(ERROR_WIDTH-1)-1) and go to IDLE. Default is +/-127; -2^(ERROR_WIDTH-1) is never produced.
REQ-020 Cycle slip: a second leading edge (ref_rise in REF_LEAD, or fb_rise in FB_LEAD) without the matching edge SHALL emit a saturated error of the leading sign and re-enter the same state with cnt=1.
REQ-021 Both edges in the same cycle in REF_LEAD or FB_LEAD SHALL be treated as the matching edge closing the measurement; the other edge is discarded.
REQ-022 error_o and error_valid_o SHALL be registered and update one cycle after the cycle in which the closing edge is detected.
REQ-023 error_o SHALL hold its last value between measurements.
REQ-024 Pin-to-error_valid_o latency SHALL be SYNC_STAGES+2 cycles.
REQ-025 Lock counter SHALL increment, saturating at LOCK_COUNT, on each valid measurement with |error|<=LOCK_TOL.
REQ-026 Any valid measurement with |error|>LOCK_TOL SHALL clear the lock counter and deassert lock_o.
REQ-027 lock_o SHALL assert when the lock counter reaches LOCK_COUNT, and SHALL update one cycle after the corresponding error_valid_o.
REQ-028 enable_i low SHALL force IDLE, clear cnt, the lock counter and lock_o, hold error_o at 0 and suppress error_valid_o; the synchronizers keep running.
REQ-029 On enable_i rising, the first measurement SHALL start at the next detected edge.

Reset
REQ-030 reset_i high at a gen_clk_i edge SHALL give: state IDLE, cnt=0, synchronizer and edge flops 0, error_o=0, error_valid_o=0, lock counter 0, lock_o=0.
REQ-031 Reset mid-measurement SHALL abandon the measurement with no error_valid_o pulse.
REQ-032 reset_i SHALL take priority over enable_i and all edge events.

Structure
REQ-033 The shared adpll package SHALL hold the FSM state encodings and the default ERROR_WIDTH, which is shared with the loop filter.
REQ-034 The synchronizer plus rising-edge detector SHALL be a sub-module, edge_sync (parameter SYNC_STAGES), instantiated once for ref_clk_i and once for fb_clk_i.

Verification
REQ-035 ref_clk_i rise, fb_clk_i rise 5 gen_clk cycles later -> one error_valid_o pulse with error_o=+5.
REQ-036 fb_clk_i rise, ref_clk_i rise 3 cycles later -> error_o=-3; both rising in the same cycle -> error_o=0.
REQ-037 ref_clk_i rise with no fb_clk_i for 200 cycles -> error_o=+127 after 127 counted cycles, then IDLE; two ref rises with no fb between them -> error_o=+127 and a new measurement starts.
REQ-038 16 consecutive measurements with error in [-2,+2] -> lock_o=1 one cycle after the 16th valid; the next measurement with error +4 -> lock_o=0.
REQ-039 reset_i pulsed in REF_LEAD at cnt=10 -> no error_valid_o, all outputs 0; enable_i dropped while locked -> lock_o=0, error_o=0, no valid pulses until re-enabled.
